// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store sequencer for a 64-bit doubleword-addressed
//               synchronous data memory. Loads are lane-extracted and
//               sign/zero-extended; sub-doubleword stores are performed as
//               read-modify-write. Misaligned and illegal requests fault.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [63:0]       load_data,
    output logic              fault,
    output logic              fault_cause,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam int                 c_CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LATENCY - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd1;
    localparam logic [2:0] c_ST_WRITE   = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
    localparam logic [2:0] c_ST_FAULT   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_cause_nxt;
    logic [2:0]         r_func3;
    logic [2:0]         r_lane;
    logic [63:0]        r_sdata;
    logic               r_is_load;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_req;
    logic               w_illegal;
    logic               w_misal;
    logic               w_accept;
    logic               w_sample;
    logic [5:0]         w_shift;
    logic [63:0]        w_rd_sh;
    logic [63:0]        w_size_mask;
    logic [63:0]        w_ext;
    logic [63:0]        w_merge;
    logic               w_sign;

    assign w_req     = req_load | req_store;
    assign w_illegal = (req_load & req_store) | (req_load & (func3 == 3'b111)) | (req_store & func3[2]);
    assign w_accept  = (r_state == c_ST_IDLE) & w_req;
    assign w_sample  = (r_state == c_ST_RD_WAIT) & (r_cnt == '0);

    // Alignment check on the incoming request, by access size
    always_comb begin
        w_misal = 1'b0;
        case (func3[1:0])
            2'b01:   w_misal = addr[0];
            2'b10:   w_misal = |addr[1:0];
            2'b11:   w_misal = |addr[2:0];
            default: w_misal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; fault priority is illegal before misaligned
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        w_state_nxt = c_ST_FAULT;
                        w_cause_nxt = 1'b1;
                    end else if (w_misal) begin
                        w_state_nxt = c_ST_FAULT;
                    end else if (req_load || (func3[1:0] != 2'b11)) begin
                        w_state_nxt = c_ST_RD_WAIT;
                    end else begin
                        w_state_nxt = c_ST_WRITE;
                    end
                end
            end
            c_ST_RD_WAIT: if (r_cnt == '0) w_state_nxt = r_is_load ? c_ST_DONE : c_ST_WRITE;
            c_ST_WRITE:   w_state_nxt = c_ST_DONE;
            c_ST_DONE:    w_state_nxt = c_ST_IDLE;
            c_ST_FAULT:   w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 1'b0;
            mem_wr      <= 1'b0;
        end else begin
            busy        <= (w_state_nxt != c_ST_IDLE);
            done        <= (w_state_nxt == c_ST_DONE) | (w_state_nxt == c_ST_FAULT);
            fault       <= (w_state_nxt == c_ST_FAULT);
            fault_cause <= (w_state_nxt == c_ST_FAULT) & w_cause_nxt;
            mem_wr      <= (w_state_nxt == c_ST_WRITE);
        end
    end

    // Lane extraction, extension and store merge on the returned doubleword
    always_comb begin
        w_shift     = {r_lane, 3'b000};
        w_rd_sh     = mem_rdata >> w_shift;
        w_sign      = ~r_func3[2];
        w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        w_ext       = w_rd_sh;
        case (r_func3[1:0])
            2'b00: begin
                w_size_mask = 64'h0000_0000_0000_00FF;
                w_ext       = {{56{w_sign & w_rd_sh[7]}}, w_rd_sh[7:0]};
            end
            2'b01: begin
                w_size_mask = 64'h0000_0000_0000_FFFF;
                w_ext       = {{48{w_sign & w_rd_sh[15]}}, w_rd_sh[15:0]};
            end
            2'b10: begin
                w_size_mask = 64'h0000_0000_FFFF_FFFF;
                w_ext       = {{32{w_sign & w_rd_sh[31]}}, w_rd_sh[31:0]};
            end
            default: begin
                w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                w_ext       = w_rd_sh;
            end
        endcase
        w_merge = (mem_rdata & ~(w_size_mask << w_shift)) | ((r_sdata & w_size_mask) << w_shift);
    end

    // Request capture, latency counter and data-path result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_func3   <= 3'b000;
            r_lane    <= 3'b000;
            r_sdata   <= 64'd0;
            r_is_load <= 1'b0;
            r_cnt     <= '0;
            mem_addr  <= '0;
            mem_wdata <= 64'd0;
            load_data <= 64'd0;
        end else begin
            if (w_accept) begin
                r_func3   <= func3;
                r_lane    <= addr[2:0];
                r_sdata   <= store_data;
                r_is_load <= req_load;
                r_cnt     <= c_CNT_INIT;
                mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                if (req_store) mem_wdata <= store_data;
            end else if (r_state == c_ST_RD_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_sample) begin
                if (r_is_load) load_data <= w_ext;
                else           mem_wdata <= w_merge;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Randomized self-checking bench for mem_access_unit with a
//               byte-level reference model and a small memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_load, req_store;
    logic [2:0]  func3;
    logic [63:0] addr, store_data;
    logic        busy, done, fault, fault_cause, mem_wr;
    logic [63:0] load_data, mem_addr, mem_wdata, mem_rdata;

    logic [63:0] mem [0:63];
    logic [63:0] ref_mem [0:63];
    logic [63:0] rd_q;
    logic        bk_we;
    logic [5:0]  bk_idx;
    logic [63:0] bk_val;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_ld   = 64'd0;

    mem_access_unit #(.MEM_LATENCY(c_L), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .req_load(req_load), .req_store(req_store),
        .func3(func3), .addr(addr), .store_data(store_data), .busy(busy),
        .done(done), .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: one register stage gives data usable at the edge two cycles after the address
    always @(posedge clk) begin
        rd_q <= mem[mem_addr[8:3]];
        if (bk_we)       mem[bk_idx] <= bk_val;
        else if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;
    end
    assign mem_rdata = rd_q;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    task automatic bd_write(input int idx, input logic [63:0] val);
        @(negedge clk);
        bk_we = 1'b1; bk_idx = 6'(idx); bk_val = val;
        @(negedge clk);
        bk_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one request and compare every observable against the model
    task automatic run_req(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] sd,
                           input bit poke, input bit kill);
        int          size, lane, idx, exp_lat, exp_wr, done_k, wr_k, wr_cnt;
        bit          exp_fault, exp_cause, got_done, killed, fault_v, cause_v;
        logic [63:0] dw, v, exp_wdata, wr_addr, wr_data;
        size = 1 << f3[1:0];
        lane = int'(a[2:0]);
        idx  = int'(a[8:3]);
        exp_cause = (ld && st) || (ld && f3 == 3'b111) || (st && f3[2]);
        exp_fault = exp_cause || ((lane % size) != 0);
        exp_wdata = 64'd0;
        if (exp_fault)      exp_lat = 1;
        else if (ld)        exp_lat = c_L + 1;
        else if (size == 8) exp_lat = 2;
        else                exp_lat = c_L + 2;
        exp_wr = (!exp_fault && st) ? 1 : 0;
        if (!exp_fault) begin
            dw = ref_mem[idx];
            if (ld) begin
                v = 64'd0;
                for (int i = 0; i < 8; i++) if (i < size) v[8*i +: 8] = dw[8*(lane+i) +: 8];
                if (!f3[2] && v[8*size-1])
                    for (int i = 0; i < 8; i++) if (i >= size) v[8*i +: 8] = 8'hFF;
                if (!kill) exp_ld = v;
            end else begin
                exp_wdata = dw;
                for (int i = 0; i < 8; i++) if (i < size) exp_wdata[8*(lane+i) +: 8] = sd[8*i +: 8];
            end
        end
        if (exp_lat < 2) poke = 1'b0;
        @(negedge clk);
        req_load = ld; req_store = st; func3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        req_load = 1'b0; req_store = 1'b0;
        got_done = 0; killed = 0; wr_cnt = 0; done_k = 0; wr_k = 0;
        fault_v = 0; cause_v = 0; wr_addr = 64'd0; wr_data = 64'd0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 1) req_load = 1'b1;
            if (poke && k == 2) req_load = 1'b0;
            if (mem_wr) begin
                wr_cnt++; wr_k = k; wr_addr = mem_addr; wr_data = mem_wdata;
                if (kill) begin
                    reset = 1'b1;
                    #1;
                    check_val("kill_mem_wr", 64'(mem_wr), 64'd0);
                    check_val("kill_busy", 64'(busy), 64'd0);
                    killed = 1;
                    break;
                end
            end
            if (done) begin
                got_done = 1; done_k = k; fault_v = fault; cause_v = fault_cause;
                break;
            end
        end
        req_load = 1'b0;
        if (killed) begin
            exp_ld = 64'd0;
            @(negedge clk);
            reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check_val("kill_no_done", 64'(done), 64'd0);
            end
            check_val("kill_load_data", load_data, exp_ld);
            check_val("kill_mem", mem[idx], ref_mem[idx]);
            return;
        end
        check_val("done_seen", 64'(got_done), 64'd1);
        if (got_done) begin
            check_val("latency", 64'(done_k), 64'(exp_lat));
            check_val("fault", 64'(fault_v), 64'(exp_fault));
            if (exp_fault) check_val("fault_cause", 64'(cause_v), 64'(exp_cause));
        end
        check_val("wr_count", 64'(wr_cnt), 64'(exp_wr));
        if (exp_wr == 1 && wr_cnt == 1) begin
            check_val("wr_cycle", 64'(wr_k), 64'(exp_lat - 1));
            check_val("wr_addr", wr_addr, a & ~64'h7);
            check_val("wr_data", wr_data, exp_wdata);
            ref_mem[idx] = exp_wdata;
        end
        @(negedge clk);
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("single_done", 64'(done), 64'd0);
        check_val("load_data", load_data, exp_ld);
        check_val("mem", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int          sel, f, sz, ln;
        logic [63:0] ra;
        reset = 1'b1; req_load = 1'b0; req_store = 1'b0; func3 = 3'b000;
        addr = 64'd0; store_data = 64'd0; bk_we = 1'b0; bk_idx = 6'd0; bk_val = 64'd0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_fault", 64'(fault), 64'd0);
        check_val("rst_mem_wr", 64'(mem_wr), 64'd0);
        check_val("rst_load_data", load_data, 64'd0);
        check_val("rst_mem_addr", mem_addr, 64'd0);
        check_val("rst_mem_wdata", mem_wdata, 64'd0);
        for (int i = 0; i < 64; i++) bd_write(i, {$urandom, $urandom});
        bd_write(32, 64'h8877665544332211);
        @(negedge clk);
        reset = 1'b0;

        run_req(1, 0, 3'b000, 64'h107, 64'd0, 0, 0);
        check_val("lb_const", load_data, 64'hFFFFFFFFFFFFFF88);
        run_req(1, 0, 3'b100, 64'h107, 64'd0, 0, 0);
        check_val("lbu_const", load_data, 64'h0000000000000088);
        run_req(0, 1, 3'b001, 64'h102, 64'h000000000000ABCD, 0, 0);
        check_val("sh_const", mem[32], 64'h88776655ABCD2211);
        run_req(0, 1, 3'b011, 64'h108, 64'h0123456789ABCDEF, 0, 0);
        check_val("sd_const", mem[33], 64'h0123456789ABCDEF);
        run_req(1, 0, 3'b010, 64'h102, 64'd0, 0, 0);
        run_req(1, 1, 3'b000, 64'h100, 64'd0, 0, 0);
        run_req(1, 0, 3'b111, 64'h100, 64'd0, 0, 0);
        run_req(0, 1, 3'b100, 64'h100, 64'd0, 0, 0);
        bd_write(32, 64'h8000000000000000);
        run_req(1, 0, 3'b010, 64'h104, 64'd0, 1, 0);
        check_val("lw_const", load_data, 64'hFFFFFFFF80000000);
        run_req(1, 0, 3'b110, 64'h104, 64'd0, 1, 0);
        check_val("lwu_const", load_data, 64'h0000000080000000);
        run_req(0, 1, 3'b001, 64'h102, 64'h1234, 0, 1);
        run_req(1, 0, 3'b011, 64'h100, 64'd0, 0, 0);
        check_val("ld_after_kill", load_data, 64'h8000000000000000);

        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 9));
            f   = int'($urandom_range(0, 7));
            sz  = 1 << (f % 4);
            ln  = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) ln = ln & ~(sz - 1);
            ra  = 64'($urandom_range(0, 63)) * 64'd8 + 64'(ln);
            run_req(sel <= 5, sel == 0 || sel > 5, 3'(f), ra, {$urandom, $urandom},
                    $urandom_range(0, 1) == 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly downstream of the multicycle control FSM.
- Receives one access request per load/store instruction: address from AOut, store data from register B, size from func3.
- Drives a 64-bit doubleword-addressed synchronous data memory.
- For loads, returns an aligned, sign- or zero-extended result for the MDR/writeback path. For byte/half/word stores, performs a read-modify-write. Misaligned and illegal-size accesses are reported to the exception path.

Parameters:
MEM_LATENCY, 1, read latency of data memory in cycles (legal >= 1)
ADDR_W, 64, byte address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_load  in  1  start load; sampled only in IDLE
req_store  in  1  start store; sampled only in IDLE
func3  in  3  size: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
addr  in  ADDR_W  byte address
store_data  in  64  store operand (low bytes used for partial stores)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
load_data  out  64  extended load result, held until next completed load
fault  out  1  one-cycle pulse coincident with done on faulting request
fault_cause  out  1  0 misaligned, 1 illegal size/request; valid while fault=1
mem_addr  out  ADDR_W  doubleword address, {addr[ADDR_W-1:3],3'b000}
mem_wr  out  1  memory write strobe
mem_wdata  out  64  write data
mem_rdata  in  64  memory read data, valid MEM_LATENCY cycles after mem_addr

Behaviour:
- Reset is asynchronous and active-high:
  - State goes to IDLE.
  - All outputs and internal registers (addr, func3, store data, latency counter, load_data) go to 0.
  - mem_wr drops immediately, including mid-write; an interrupted access is abandoned and produces no done.
- All outputs are registered.
- States: IDLE, RD_WAIT, WRITE, DONE, FAULT.
- IDLE:
  - On req_load or req_store, latch addr, func3 and store_data, then check the request in this order:
  - 1. Both requests high, a load with func3=111, or a store with func3[2]=1 → FAULT, fault_cause=1.
  - 2. Misaligned (h/hu addr[0]!=0; w/wu addr[1:0]!=0; d addr[2:0]!=0) → FAULT, fault_cause=0.
  - 3. Load, or a store with size b/h/w → RD_WAIT, counter=MEM_LATENCY-1.
  - 4. Store d → WRITE.
- RD_WAIT:
  - Holds mem_addr, mem_wr=0; decrements the counter each cycle.
  - At counter 0, mem_rdata is sampled.
  - Load: extract the byte lane selected by addr[2:0], extend (sign for b/h/w, zero for bu/hu/wu), register into load_data, go to DONE.
  - Store: merge store_data[size-1:0] into the sampled doubleword at lane addr[2:0], register into mem_wdata, go to WRITE.
- WRITE:
  - mem_wr=1 for exactly one cycle with mem_addr and mem_wdata. For d stores, mem_wdata=store_data.
  - Next state DONE.
- DONE: done=1 for one cycle → IDLE.
- FAULT:
  - done=1, fault=1 for one cycle → IDLE.
  - No memory write and no read wait; load_data unchanged.
- Latency from the request cycle (L=MEM_LATENCY):
  - Load: done L+1 cycles later.
  - Full store: done 2 cycles later.
  - Partial store: done L+2 cycles later.
  - Fault: done 1 cycle later.
- Requests while busy are ignored; no queuing. A new request may be accepted in the cycle after DONE/FAULT.
- Unselected bytes of a partial store keep their prior memory value exactly.

Test Plan:
- MEM_LATENCY=2, mem[0x100]=0x8877665544332211, lb addr=0x107 → done 3 cycles after req, load_data=0xFFFFFFFFFFFFFF88; lbu same addr → 0x0000000000000088.
- Same memory, sh addr=0x102 store_data=0x000000000000ABCD → one mem_wr pulse 3 cycles after req, mem_wdata=0x88776655ABCD2211, done 4 cycles after req.
- sd addr=0x108 store_data=0x0123456789ABCDEF → mem_wr at cycle 1 with mem_addr=0x108, mem_wdata=0x0123456789ABCDEF, done at cycle 2; no read phase.
- lw addr=0x102 → fault=1, fault_cause=0, done at cycle 1, mem_wr never high, load_data unchanged; req_load and req_store both high → fault_cause=1.
- lw addr=0x104 on mem 0x80000000_00000000 → load_data=0xFFFFFFFF80000000; lwu → 0x0000000080000000; req_load pulsed during RD_WAIT is ignored (exactly one done).
- Assert reset during WRITE of a partial store → mem_wr drops the same cycle, busy=0, done never pulses; a subsequent ld completes normally.
